// File: rtl/i8284_gen.sv
// Clock, reset and ready generator for the i8088 breadboard: divided CPU clock,
// half-rate peripheral clock, CLK_OUT-aligned reset stretcher and READY synchroniser.
module i8284_gen #(
    parameter int DIV      = 3,
    parameter int HIGH_CYC = 1,
    parameter int RST_CLKS = 4
) (
    input  logic CLK_IN,
    input  logic RST,
    input  logic RESN,
    input  logic RDY1,
    input  logic RDY2,
    input  logic AEN1N,
    input  logic AEN2N,
    input  logic ASYNCN,
    output logic CLK_OUT,
    output logic PCLK,
    output logic CLK_STB,
    output logic RESET,
    output logic READY,
    output logic DBG_STATE
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = (RST_CLKS > 1) ? $clog2(RST_CLKS) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PH_FALL = PW'(HIGH_CYC - 1);
    localparam logic [PW-1:0] PH_HIGH = PW'(HIGH_CYC);
    localparam logic [CW-1:0] CNT_MAX = CW'(RST_CLKS - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } rst_state_t;

    logic [PW-1:0] phase;
    logic [PW-1:0] phase_nxt;
    logic          tick;
    logic          fall_edge;
    logic          resn_a;
    logic          resn_s;
    rst_state_t    state;
    logic [CW-1:0] cnt;
    logic          req;
    logic          s1;
    logic          s2;
    logic          ready_sel;

    assign tick      = (phase == PH_LAST);
    assign fall_edge = (phase == PH_FALL);
    assign phase_nxt = tick ? '0 : phase + PW'(1);

    // Outputs are decoded from the next phase so they change in lockstep with it.
    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            phase   <= '0;
            CLK_OUT <= 1'b0;
            CLK_STB <= 1'b0;
            PCLK    <= 1'b0;
        end else begin
            phase   <= phase_nxt;
            CLK_OUT <= (phase_nxt < PH_HIGH);
            CLK_STB <= (phase_nxt == '0);
            if (tick) begin
                PCLK <= ~PCLK;
            end
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            resn_a <= 1'b1;
            resn_s <= 1'b1;
        end else begin
            resn_a <= RESN;
            resn_s <= resn_a;
        end
    end

    assign req = (RDY1 & ~AEN1N) | (RDY2 & ~AEN2N);

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            if (tick) begin
                s1 <= req;
            end
            if (fall_edge) begin
                s2 <= s1;
            end
        end
    end

    assign ready_sel = ASYNCN ? s1 : s2;

    // READY is gated by the RESET value written on the same edge, so it is
    // never high in a cycle where RESET is high.
    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            state <= ST_ACTIVE;
            cnt   <= '0;
            RESET <= 1'b1;
            READY <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!resn_s) begin
                        state <= ST_ACTIVE;
                        cnt   <= '0;
                        RESET <= 1'b1;
                        READY <= 1'b0;
                    end else begin
                        READY <= ready_sel;
                    end
                end
                ST_ACTIVE: begin
                    READY <= 1'b0;
                    if (tick) begin
                        if (cnt == CNT_MAX && resn_s) begin
                            state <= ST_IDLE;
                            RESET <= 1'b0;
                            READY <= ready_sel;
                        end else if (cnt != CNT_MAX) begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_ACTIVE;
                    cnt   <= '0;
                    RESET <= 1'b1;
                    READY <= 1'b0;
                end
            endcase
        end
    end

    assign DBG_STATE = (state == ST_ACTIVE);

endmodule

// File: tb/tb_i8284_gen.sv
// Bench for i8284_gen: default and DIV=5/HIGH_CYC=2 instances share all inputs;
// a vector table, directed corner sequences and random traffic against a reference model.
module tb_i8284_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, resn, rdy1, rdy2, aen1n, aen2n, asyncn;
    logic [1:0] clk_out, pclk, clk_stb, reset_o, ready, dbg_state;

    i8284_gen u_a (
        .CLK_IN(clk), .RST(rst), .RESN(resn), .RDY1(rdy1), .RDY2(rdy2),
        .AEN1N(aen1n), .AEN2N(aen2n), .ASYNCN(asyncn),
        .CLK_OUT(clk_out[0]), .PCLK(pclk[0]), .CLK_STB(clk_stb[0]),
        .RESET(reset_o[0]), .READY(ready[0]), .DBG_STATE(dbg_state[0])
    );

    i8284_gen #(.DIV(5), .HIGH_CYC(2), .RST_CLKS(4)) u_b (
        .CLK_IN(clk), .RST(rst), .RESN(resn), .RDY1(rdy1), .RDY2(rdy2),
        .AEN1N(aen1n), .AEN2N(aen2n), .ASYNCN(asyncn),
        .CLK_OUT(clk_out[1]), .PCLK(pclk[1]), .CLK_STB(clk_stb[1]),
        .RESET(reset_o[1]), .READY(ready[1]), .DBG_STATE(dbg_state[1])
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [5:0] exp_q[$];

    // Reference model: time is counted in CLK_IN edges since the last RST edge.
    int m_div[2]  = '{3, 5};
    int m_high[2] = '{1, 2};
    localparam int M_RCLKS = 4;
    int m_k[2];
    bit m_act[2];
    int m_cnt[2];
    bit m_s1[2];
    bit m_s2[2];
    bit m_rdy[2];
    bit rq[$];

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_step();
        bit used, req, s1_old, s2_old, tick, fall;
        int ph;
        if (rst) begin
            rq = '{1'b1, 1'b1};
            for (int i = 0; i < 2; i++) begin
                m_k[i] = 0; m_act[i] = 1; m_cnt[i] = 0;
                m_s1[i] = 0; m_s2[i] = 0; m_rdy[i] = 0;
            end
        end else begin
            used = rq.pop_front();
            rq.push_back(resn);
            req = (rdy1 && !aen1n) || (rdy2 && !aen2n);
            for (int i = 0; i < 2; i++) begin
                ph = m_k[i] % m_div[i];
                tick = (ph == m_div[i] - 1);
                fall = (ph == m_high[i] - 1);
                s1_old = m_s1[i];
                s2_old = m_s2[i];
                m_k[i]++;
                if (tick) m_s1[i] = req;
                if (fall) m_s2[i] = s1_old;
                if (!m_act[i]) begin
                    if (!used) begin m_act[i] = 1; m_cnt[i] = 0; end
                end else if (tick) begin
                    if (m_cnt[i] == M_RCLKS - 1 && used) m_act[i] = 0;
                    else if (m_cnt[i] < M_RCLKS - 1) m_cnt[i]++;
                end
                m_rdy[i] = m_act[i] ? 1'b0 : (asyncn ? s1_old : s2_old);
            end
        end
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({
                logic'(m_k[i] > 0 && (m_k[i] % m_div[i]) < m_high[i]),
                logic'(((m_k[i] / m_div[i]) % 2) == 1),
                logic'(m_k[i] > 0 && (m_k[i] % m_div[i]) == 0),
                logic'(m_act[i]),
                logic'(m_rdy[i]),
                logic'(m_act[i])
            });
        end
    endtask

    task automatic cycle();
        logic [5:0] w;
        string t;
        @(posedge clk);
        #1;
        model_step();
        for (int i = 0; i < 2; i++) begin
            t = (i == 0) ? "a" : "b";
            w = exp_q.pop_front();
            check_bit({"clk_out_", t}, clk_out[i], w[5]);
            check_bit({"pclk_", t}, pclk[i], w[4]);
            check_bit({"clk_stb_", t}, clk_stb[i], w[3]);
            check_bit({"reset_", t}, reset_o[i], w[2]);
            check_bit({"ready_", t}, ready[i], w[1]);
            check_bit({"dbg_state_", t}, dbg_state[i], w[0]);
        end
    endtask

    task automatic wait_rise();
        bit ok;
        ok = 0;
        for (int n = 0; n < 12; n++) begin
            cycle();
            if (clk_out[0]) begin ok = 1; break; end
        end
        check_bit("clk_rise_seen", ok, 1'b1);
    endtask

    typedef struct {
        logic       rst;
        logic       resn;
        logic       rdy1;
        logic       aen1n;
        logic [4:0] exp;   // {clk_out, pclk, clk_stb, reset, ready}
    } vec_t;

    vec_t vecs[17];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_hi, low_left;
        bit fell;
        rst = 1; resn = 1; rdy1 = 1; rdy2 = 0; aen1n = 1; aen2n = 1; asyncn = 1;

        // Power-on sequence of the default instance, edge 0 is the RST edge.
        vecs = '{
            '{1'b1, 1'b1, 1'b1, 1'b1, 5'b00010},
            '{1'b0, 1'b1, 1'b1, 1'b1, 5'b00010},
            '{1'b0, 1'b1, 1'b1, 1'b1, 5'b00010},
            '{1'b0, 1'b1, 1'b1, 1'b1, 5'b11110},
            '{1'b0, 1'b1, 1'b1, 1'b1, 5'b01010},
            '{1'b0, 1'b1, 1'b1, 1'b1, 5'b01010},
            '{1'b0, 1'b1, 1'b1, 1'b1, 5'b10110},
            '{1'b0, 1'b1, 1'b1, 1'b1, 5'b00010},
            '{1'b0, 1'b1, 1'b1, 1'b1, 5'b00010},
            '{1'b0, 1'b1, 1'b1, 1'b1, 5'b11110},
            '{1'b0, 1'b1, 1'b1, 1'b1, 5'b01010},
            '{1'b0, 1'b1, 1'b1, 1'b1, 5'b01010},
            '{1'b0, 1'b1, 1'b1, 1'b1, 5'b10100},
            '{1'b0, 1'b1, 1'b1, 1'b1, 5'b00000},
            '{1'b0, 1'b1, 1'b1, 1'b1, 5'b00000},
            '{1'b0, 1'b1, 1'b1, 1'b1, 5'b11100},
            '{1'b0, 1'b1, 1'b1, 1'b1, 5'b01000}
        };
        for (int v = 0; v < 17; v++) begin
            rst = vecs[v].rst; resn = vecs[v].resn;
            rdy1 = vecs[v].rdy1; aen1n = vecs[v].aen1n;
            cycle();
            check_bit($sformatf("vec%0d_clk_out", v), clk_out[0], vecs[v].exp[4]);
            check_bit($sformatf("vec%0d_pclk", v), pclk[0], vecs[v].exp[3]);
            check_bit($sformatf("vec%0d_clk_stb", v), clk_stb[0], vecs[v].exp[2]);
            check_bit($sformatf("vec%0d_reset", v), reset_o[0], vecs[v].exp[1]);
            check_bit($sformatf("vec%0d_ready", v), ready[0], vecs[v].exp[0]);
        end

        // READY, one-stage mode: rises one CLK_IN cycle after the next CLK_OUT rise.
        rdy1 = 0; aen1n = 0; asyncn = 1;
        repeat (8) cycle();
        check_bit("async_idle", ready[0], 1'b0);
        rdy1 = 1;
        wait_rise();
        check_bit("async_at_rise", ready[0], 1'b0);
        cycle();
        check_bit("async_rise_lat", ready[0], 1'b1);
        rdy1 = 0;
        wait_rise();
        check_bit("async_hold_at_rise", ready[0], 1'b1);
        cycle();
        check_bit("async_fall_lat", ready[0], 1'b0);

        // READY, two-stage mode: rises one CLK_IN cycle after the following fall.
        asyncn = 0;
        repeat (8) cycle();
        check_bit("sync_idle", ready[0], 1'b0);
        rdy1 = 1;
        wait_rise();
        check_bit("sync_at_rise", ready[0], 1'b0);
        cycle();
        check_bit("sync_at_fall_clk", clk_out[0], 1'b0);
        check_bit("sync_at_fall", ready[0], 1'b0);
        cycle();
        check_bit("sync_rise_lat", ready[0], 1'b1);

        // Qualifier high blocks the request.
        rdy1 = 0;
        repeat (10) cycle();
        aen1n = 1; rdy1 = 1;
        for (int n = 0; n < 12; n++) begin
            cycle();
            check_bit("aen_gate_a", ready[0], 1'b0);
            check_bit("aen_gate_b", ready[1], 1'b0);
        end

        // External reset request held low for 20 cycles.
        resn = 0;
        cycle(); check_bit("resn_lat_e1", reset_o[0], 1'b0);
        cycle(); check_bit("resn_lat_e2", reset_o[0], 1'b0);
        cycle(); check_bit("resn_lat_e3", reset_o[0], 1'b1);
        for (int n = 0; n < 17; n++) begin
            cycle();
            check_bit("resn_hold", reset_o[0], 1'b1);
        end
        resn = 1;
        fell = 0;
        for (int n = 0; n < 30; n++) begin
            cycle();
            check_bit("ready_low_in_reset", ready[0] & reset_o[0], 1'b0);
            if (!reset_o[0]) begin fell = 1; break; end
        end
        check_bit("resn_release_seen", fell, 1'b1);
        check_bit("resn_release_on_rise", clk_out[0], 1'b1);

        // RST while ACTIVE with cnt=2 restarts the whole stretch.
        rst = 1; cycle(); rst = 0;
        repeat (7) cycle();
        check_bit("mid_still_active", reset_o[0], 1'b1);
        rst = 1; cycle(); rst = 0;
        check_bit("mid_rst_reset", reset_o[0], 1'b1);
        n_hi = 0;
        for (int n = 0; n < 40; n++) begin
            cycle();
            if (!reset_o[0]) break;
            n_hi++;
        end
        check_int("mid_rst_high_cycles", n_hi, 11);
        check_bit("mid_rst_fall_on_rise", clk_out[0], 1'b1);

        // Random traffic against the model, one block per synchroniser mode.
        low_left = 0;
        for (int blk = 0; blk < 2; blk++) begin
            asyncn = logic'(blk);
            for (int n = 0; n < 1500; n++) begin
                if ($urandom_range(0, 3) == 0) begin
                    rdy1 = logic'($urandom_range(0, 1));
                    rdy2 = logic'($urandom_range(0, 1));
                    aen1n = logic'($urandom_range(0, 1));
                    aen2n = logic'($urandom_range(0, 1));
                end
                if (low_left > 0) begin
                    low_left--;
                    resn = 0;
                end else if ($urandom_range(0, 99) == 0) begin
                    low_left = $urandom_range(0, 24);
                    resn = 0;
                end else begin
                    resn = 1;
                end
                rst = ($urandom_range(0, 299) == 0);
                cycle();
            end
        end
        rst = 0; resn = 1;
        repeat (4) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
